hybrid_hamming_codec: RTL and testbench

- Registered 44-bit burst-tolerant codec, one clock domain, with independent encode and decode paths.
- Encode: interleave the 44 data bits, then encode 11 data nibbles plus 4 group-parity nibbles as 15 Hamming(7,4) codewords, then bit-interleave them into a 105-bit word.
- Decode: invert each step, correct one error per codeword, and flag residual errors.
- Sits between the data source and the channel/storage model.

---
 rtl/hhc_pkg.sv | 60 ++++++
 rtl/hybrid_hamming_codec_dec.sv | 27 ++
 rtl/hybrid_hamming_codec.sv | 93 +++++++++
 tb/tb_hybrid_hamming_codec.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hhc_pkg.sv
// Shared constants and pure helper functions for the hybrid Hamming codec:
// data interleave, Hamming(7,4) encode and codeword/stream bit interleave.
package hhc_pkg;

  localparam int DATA_W = 44;
  localparam int CW_N   = 15;
  localparam int CW_W   = 7;
  localparam int ENC_W  = 105;
  localparam int NIB_N  = 11;
  localparam int GRP_N  = 4;

  // Codeword bit order is position-1: p1 p2 d0 p3 d1 d2 d3
  function automatic logic [CW_W-1:0] ham74_enc(input logic [3:0] d);
    logic [CW_W-1:0] cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] data_interleave(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] il;
    il = '0;
    for (int c = 0; c < NIB_N; c++)
      for (int k = 0; k < 4; k++)
        il[4*c+k] = d[NIB_N*k+c];
    return il;
  endfunction

  function automatic logic [DATA_W-1:0] data_deinterleave(input logic [DATA_W-1:0] il);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int c = 0; c < NIB_N; c++)
      for (int k = 0; k < 4; k++)
        d[NIB_N*k+c] = il[4*c+k];
    return d;
  endfunction

  // cw_flat holds codeword j at bits [CW_W*j +: CW_W]
  function automatic logic [ENC_W-1:0] stream_map(input logic [ENC_W-1:0] cw_flat);
    logic [ENC_W-1:0] s;
    s = '0;
    for (int i = 0; i < ENC_W; i++)
      s[i] = cw_flat[CW_W*(i%CW_N) + i/CW_N];
    return s;
  endfunction

  function automatic logic [ENC_W-1:0] stream_unmap(input logic [ENC_W-1:0] s);
    logic [ENC_W-1:0] cw_flat;
    cw_flat = '0;
    for (int i = 0; i < ENC_W; i++)
      cw_flat[CW_W*(i%CW_N) + i/CW_N] = s[i];
    return cw_flat;
  endfunction

endpackage

// File: rtl/hybrid_hamming_codec_dec.sv
// Single Hamming(7,4) codeword corrector: fixes one bit error, returns the
// data nibble and whether the syndrome was nonzero.
module hamming74_dec
  import hhc_pkg::*;
(
  input  logic [CW_W-1:0] cw,
  output logic [3:0]      data,
  output logic            err
);

  logic [2:0]      syn;
  logic [CW_W-1:0] flip;
  logic [CW_W-1:0] fixed;

  always_comb begin
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    flip   = '0;
    if (syn != 3'd0)
      flip = CW_W'(1) << (syn - 3'd1);
    fixed = cw ^ flip;
    data  = {fixed[6], fixed[5], fixed[4], fixed[2]};
    err   = |syn;
  end

endmodule

// File: rtl/hybrid_hamming_codec.sv
// Burst-tolerant 44-bit codec: independent 1-cycle encode and decode paths
// built from 15 bit-interleaved Hamming(7,4) codewords with group parity.
module hybrid_hamming_codec
  import hhc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enc_valid,
  input  logic [DATA_W-1:0] enc_data,
  output logic              enc_out_valid,
  output logic [ENC_W-1:0]  enc_out,
  input  logic              dec_valid,
  input  logic [ENC_W-1:0]  dec_in,
  output logic              dec_out_valid,
  output logic [DATA_W-1:0] dec_data,
  output logic              dec_corrected,
  output logic              dec_uncorrectable
);

  // Group g collects data nibbles c with c mod 4 == g
  function automatic logic [4*GRP_N-1:0] grp_parity(input logic [DATA_W-1:0] nibs);
    logic [4*GRP_N-1:0] p;
    p = '0;
    for (int c = 0; c < NIB_N; c++)
      p[4*(c%GRP_N) +: 4] = p[4*(c%GRP_N) +: 4] ^ nibs[4*c +: 4];
    return p;
  endfunction

  logic [DATA_W-1:0]  enc_il;
  logic [4*CW_N-1:0]  enc_nib;
  logic [ENC_W-1:0]   enc_cw;
  logic [ENC_W-1:0]   rx_cw;
  logic [4*CW_N-1:0]  rx_nib;
  logic [CW_N-1:0]    syn_nz;
  logic               grp_bad;

  logic               enc_vld_p1;
  logic [ENC_W-1:0]   enc_word_p1;
  logic               dec_vld_p1;
  logic [DATA_W-1:0]  dec_data_p1;
  logic               dec_corr_p1;
  logic               dec_unc_p1;

  always_comb begin
    enc_il  = data_interleave(enc_data);
    enc_nib = {grp_parity(enc_il), enc_il};
    enc_cw  = '0;
    for (int j = 0; j < CW_N; j++)
      enc_cw[CW_W*j +: CW_W] = ham74_enc(enc_nib[4*j +: 4]);
  end

  assign rx_cw = stream_unmap(dec_in);

  for (genvar j = 0; j < CW_N; j++) begin : g_dec
    hamming74_dec u_dec (
      .cw   (rx_cw[CW_W*j +: CW_W]),
      .data (rx_nib[4*j +: 4]),
      .err  (syn_nz[j])
    );
  end

  assign grp_bad = grp_parity(rx_nib[DATA_W-1:0]) != rx_nib[4*CW_N-1:DATA_W];

  // p0 -> p1: both paths register on their own valid; data holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_vld_p1  <= 1'b0;
      enc_word_p1 <= '0;
      dec_vld_p1  <= 1'b0;
      dec_data_p1 <= '0;
      dec_corr_p1 <= 1'b0;
      dec_unc_p1  <= 1'b0;
    end else begin
      enc_vld_p1 <= enc_valid;
      dec_vld_p1 <= dec_valid;
      if (enc_valid)
        enc_word_p1 <= stream_map(enc_cw);
      if (dec_valid) begin
        dec_data_p1 <= data_deinterleave(rx_nib[DATA_W-1:0]);
        dec_corr_p1 <= |syn_nz;
        dec_unc_p1  <= grp_bad;
      end
    end
  end

  assign enc_out_valid     = enc_vld_p1;
  assign enc_out           = enc_word_p1;
  assign dec_out_valid     = dec_vld_p1;
  assign dec_data          = dec_data_p1;
  assign dec_corrected     = dec_corr_p1;
  assign dec_uncorrectable = dec_unc_p1;

endmodule

// File: tb/tb_hybrid_hamming_codec.sv
// Directed self-checking bench for hybrid_hamming_codec with hand-derived
// expected encodings and error-injection decode cases.
module tb_hybrid_hamming_codec;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enc_valid;
  logic [43:0]  enc_data;
  logic         enc_out_valid;
  logic [104:0] enc_out;
  logic         dec_valid;
  logic [104:0] dec_in;
  logic         dec_out_valid;
  logic [43:0]  dec_data;
  logic         dec_corrected;
  logic         dec_uncorrectable;

  int n_checks = 0;
  int n_pass   = 0;

  hybrid_hamming_codec dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enc_valid         (enc_valid),
    .enc_data          (enc_data),
    .enc_out_valid     (enc_out_valid),
    .enc_out           (enc_out),
    .dec_valid         (dec_valid),
    .dec_in            (dec_in),
    .dec_out_valid     (dec_out_valid),
    .dec_data          (dec_data),
    .dec_corrected     (dec_corrected),
    .dec_uncorrectable (dec_uncorrectable)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [104:0] obs, input logic [104:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_enc(input logic [43:0] d, output logic [104:0] w);
    enc_data  = d;
    enc_valid = 1'b1;
    @(posedge clk); #1;
    enc_valid = 1'b0;
    chk("enc_out_valid", 105'(enc_out_valid), 105'(1));
    w = enc_out;
  endtask

  task automatic do_dec(input logic [104:0] w);
    dec_in    = w;
    dec_valid = 1'b1;
    @(posedge clk); #1;
    dec_valid = 1'b0;
    chk("dec_out_valid", 105'(dec_out_valid), 105'(1));
  endtask

  initial begin
    logic [104:0] w;
    logic [104:0] e;
    logic [63:0]  r;
    logic [43:0]  d;
    int           j, b1, b2;

    rst_n     = 1'b0;
    enc_valid = 1'b1;
    dec_valid = 1'b1;
    enc_data  = 44'hFFFFFFFFFFF;
    dec_in    = '1;

    // Reset with both valids high
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enc_vld", 105'(enc_out_valid), 105'(0));
    chk("rst_enc_out", enc_out, 105'(0));
    chk("rst_dec_vld", 105'(dec_out_valid), 105'(0));
    chk("rst_dec_data", 105'(dec_data), 105'(0));
    chk("rst_dec_corr", 105'(dec_corrected), 105'(0));
    chk("rst_dec_unc", 105'(dec_uncorrectable), 105'(0));
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_enc_vld", 105'(enc_out_valid), 105'(0));
    chk("post_rst_dec_vld", 105'(dec_out_valid), 105'(0));

    // Zero word, then single-cycle valid
    do_enc(44'h0, w);
    chk("enc_zero", w, 105'(0));
    @(posedge clk); #1;
    chk("enc_vld_one_cycle", 105'(enc_out_valid), 105'(0));

    // All ones: codeword 14 (group 3 parity) is zero
    do_enc(44'hFFFFFFFFFFF, w);
    e = '0;
    for (int i = 0; i < 105; i++) e[i] = (i % 15 != 14);
    chk("enc_ones", w, e);
    enc_data = 44'h123456789AB;
    repeat (2) @(posedge clk);
    #1;
    chk("enc_hold_vld", 105'(enc_out_valid), 105'(0));
    chk("enc_hold_data", enc_out, e);

    // Data bit 0: nibble 0 = 1 -> cw0 = cw11 = 7'h07
    do_enc(44'h00000000001, w);
    e = '0;
    e[0] = 1'b1; e[15] = 1'b1; e[30] = 1'b1;
    e[11] = 1'b1; e[26] = 1'b1; e[41] = 1'b1;
    chk("enc_bit0", w, e);
    do_dec(w);
    chk("dec_bit0_data", 105'(dec_data), 105'(44'h1));
    chk("dec_bit0_corr", 105'(dec_corrected), 105'(0));

    // Data bit 43: nibble 10 d3 -> cw10 = cw13 = 7'h4B
    do_enc(44'h80000000000, w);
    e = '0;
    e[10] = 1'b1; e[25] = 1'b1; e[55] = 1'b1; e[100] = 1'b1;
    e[13] = 1'b1; e[28] = 1'b1; e[58] = 1'b1; e[103] = 1'b1;
    chk("enc_bit43", w, e);

    // Single error on a parity bit, then clean loopback
    do_enc(44'h123456789AB, w);
    w[0] = ~w[0];
    do_dec(w);
    chk("dec_flip0_data", 105'(dec_data), 105'(44'h123456789AB));
    chk("dec_flip0_corr", 105'(dec_corrected), 105'(1));
    chk("dec_flip0_unc", 105'(dec_uncorrectable), 105'(0));
    w[0] = ~w[0];
    do_dec(w);
    chk("dec_clean_data", 105'(dec_data), 105'(44'h123456789AB));
    chk("dec_clean_corr", 105'(dec_corrected), 105'(0));
    chk("dec_clean_unc", 105'(dec_uncorrectable), 105'(0));
    @(posedge clk); #1;
    chk("dec_vld_one_cycle", 105'(dec_out_valid), 105'(0));
    chk("dec_hold_data", 105'(dec_data), 105'(44'h123456789AB));

    // Adjacent bits 40,41 hit codewords 10 and 11
    do_enc(44'hAAAAAAAAAAA, w);
    w[40] = ~w[40];
    w[41] = ~w[41];
    do_dec(w);
    chk("dec_pair_data", 105'(dec_data), 105'(44'hAAAAAAAAAAA));
    chk("dec_pair_corr", 105'(dec_corrected), 105'(1));
    chk("dec_pair_unc", 105'(dec_uncorrectable), 105'(0));

    // 15-bit burst 30..44 touches every codeword once
    do_enc(44'hAAAAAAAAAAA, w);
    for (int i = 30; i <= 44; i++) w[i] = ~w[i];
    do_dec(w);
    chk("dec_burst_data", 105'(dec_data), 105'(44'hAAAAAAAAAAA));
    chk("dec_burst_corr", 105'(dec_corrected), 105'(1));
    chk("dec_burst_unc", 105'(dec_uncorrectable), 105'(0));

    // Double error inside codeword 0
    do_enc(44'h123456789AB, w);
    w[0]  = ~w[0];
    w[15] = ~w[15];
    do_dec(w);
    chk("dec_dbl_corr", 105'(dec_corrected), 105'(1));
    chk("dec_dbl_unc", 105'(dec_uncorrectable), 105'(1));

    // Double errors in random single codewords, including parity codewords
    for (int n = 0; n < 8; n++) begin
      r  = {$urandom, $urandom};
      d  = r[43:0];
      j  = $urandom_range(0, 14);
      b1 = $urandom_range(0, 6);
      b2 = (b1 + $urandom_range(1, 6)) % 7;
      do_enc(d, w);
      w[15*b1 + j] = ~w[15*b1 + j];
      w[15*b2 + j] = ~w[15*b2 + j];
      do_dec(w);
      chk("dec_rand_dbl_unc", 105'(dec_uncorrectable), 105'(1));
    end

    // Simultaneous encode and decode in one cycle
    enc_data  = 44'h00000000001;
    enc_valid = 1'b1;
    dec_in    = '0;
    dec_in[30] = 1'b1;
    dec_valid = 1'b1;
    @(posedge clk); #1;
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    e = '0;
    e[0] = 1'b1; e[15] = 1'b1; e[30] = 1'b1;
    e[11] = 1'b1; e[26] = 1'b1; e[41] = 1'b1;
    chk("sim_enc_vld", 105'(enc_out_valid), 105'(1));
    chk("sim_enc_out", enc_out, e);
    chk("sim_dec_vld", 105'(dec_out_valid), 105'(1));
    chk("sim_dec_data", 105'(dec_data), 105'(0));
    chk("sim_dec_corr", 105'(dec_corrected), 105'(1));

    // Reset mid-operation discards the in-flight result
    enc_data  = 44'hFFFFFFFFFFF;
    enc_valid = 1'b1;
    dec_in    = '1;
    dec_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_enc_vld", 105'(enc_out_valid), 105'(0));
    chk("midrst_enc_out", enc_out, 105'(0));
    chk("midrst_dec_data", 105'(dec_data), 105'(0));
    chk("midrst_dec_corr", 105'(dec_corrected), 105'(0));
    @(posedge clk); #1;
    chk("midrst_hold_vld", 105'(dec_out_valid), 105'(0));
    enc_valid = 1'b0;
    dec_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;
    do_enc(44'hFFFFFFFFFFF, w);
    e = '0;
    for (int i = 0; i < 105; i++) e[i] = (i % 15 != 14);
    chk("after_rst_enc", w, e);
    do_dec(w);
    chk("after_rst_dec", 105'(dec_data), 105'(44'hFFFFFFFFFFF));
    chk("after_rst_unc", 105'(dec_uncorrectable), 105'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
